// File: rtl/dwt_pkg.sv
// rtl/dwt_pkg.sv - shared widths, offset and sideband record for the DWT Haar datapath
package dwt_pkg;

   localparam int PIX_W = 8;
   localparam int PAIR_W = 16;
   localparam logic [PIX_W-1:0] HIGH_OFFSET = 8'd128;
   localparam int MAX_PTR_W = 16;

   // Pointers are carried at a fixed maximum width; each user narrows them to its own extent
   typedef struct packed {
      logic [MAX_PTR_W-1:0] row_column_pointer;
      logic [MAX_PTR_W-1:0] pixel_pointer;
      logic                 valid;
      logic                 line_end;
      logic                 pass_end;
   } side_t;

   function automatic int ptr_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/haar_lifting_mac_if.sv
// rtl/haar_lifting_mac_if.sv - pixel-pair request and coefficient response bundle
interface haar_lifting_mac_if import dwt_pkg::*; #(
   parameter int WIDTH = 256
) ();

   localparam int PW = ptr_w(WIDTH);

   logic [PAIR_W-1:0] i_pix;
   logic              i_pix_valid;
   logic [PW-1:0]     i_row_column_pointer;
   logic [PW-1:0]     i_pixel_pointer;
   logic              i_mode;
   logic [2:0]        i_level;
   logic [PAIR_W-1:0] o_coef;
   logic              o_coef_valid;
   logic [PW-1:0]     o_row_column_pointer;
   logic [PW-1:0]     o_pixel_pointer;
   logic              o_line_done;
   logic              o_pass_done;
   logic              o_seq_error;

   modport master (
      output i_pix, i_pix_valid, i_row_column_pointer, i_pixel_pointer, i_mode, i_level,
      input  o_coef, o_coef_valid, o_row_column_pointer, o_pixel_pointer,
      input  o_line_done, o_pass_done, o_seq_error
   );

   modport slave (
      input  i_pix, i_pix_valid, i_row_column_pointer, i_pixel_pointer, i_mode, i_level,
      output o_coef, o_coef_valid, o_row_column_pointer, o_pixel_pointer,
      output o_line_done, o_pass_done, o_seq_error
   );

endinterface

// File: rtl/haar_pair_kernel.sv
// rtl/haar_pair_kernel.sv - two-stage Haar pair: sum/diff, then halve and offset the high band
module haar_pair_kernel import dwt_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic [PAIR_W-1:0] pix,
   input  logic              valid,
   output logic [PAIR_W-1:0] coef,
   output logic              coef_valid
);

   logic [PIX_W-1:0]        a;
   logic [PIX_W-1:0]        b;
   logic [PIX_W:0]          sum;
   logic signed [PIX_W:0]   diff;
   logic                    v1;

   assign a = pix[PAIR_W-1:PIX_W];
   assign b = pix[PIX_W-1:0];

   // floor(diff/2) spans -128..127, so adding the offset lands exactly in 0..255
   always_ff @(posedge clk) begin
      if (rst) begin
         sum        <= '0;
         diff       <= '0;
         v1         <= 1'b0;
         coef       <= '0;
         coef_valid <= 1'b0;
      end else begin
         v1 <= valid;
         if (valid) begin
            sum  <= {1'b0, a} + {1'b0, b};
            diff <= {1'b0, a} - {1'b0, b};
         end
         coef_valid <= v1;
         if (v1) begin
            coef <= {PIX_W'(sum >> 1), PIX_W'(diff >>> 1) + HIGH_OFFSET};
         end
      end
   end

endmodule

// File: rtl/haar_lifting_mac.sv
// rtl/haar_lifting_mac.sv - Haar pair responder with pointer alignment and raster sequence checking
module haar_lifting_mac import dwt_pkg::*; #(
   parameter int HEIGHT              = 256,
   parameter int WIDTH               = 256,
   parameter int DECOMPOSITION_LEVEL = 1
) (
   input  logic               clk,
   input  logic               rst,
   haar_lifting_mac_if.slave  bus
);

   localparam int PW = ptr_w(WIDTH);

   logic [2:0]    lvl;
   logic [31:0]   line_len;
   logic [31:0]   num_lines;
   logic          line_end;
   logic          pass_end;
   logic [PW-1:0] exp_pix;
   logic [PW-1:0] exp_line;
   logic          seq_error;
   side_t         s1;
   side_t         s2;
   logic          kern_valid;

   always_comb begin
      lvl = (bus.i_level > 3'(DECOMPOSITION_LEVEL)) ? 3'(DECOMPOSITION_LEVEL) : bus.i_level;
      line_len  = (bus.i_mode ? 32'(HEIGHT) : 32'(WIDTH)) >> lvl;
      num_lines = (bus.i_mode ? 32'(WIDTH) : 32'(HEIGHT)) >> lvl;
      line_end  = (32'(bus.i_pixel_pointer) == line_len - 32'd2);
      pass_end  = line_end && (32'(bus.i_row_column_pointer) == num_lines - 32'd1);
   end

   // Counters follow the received pointers, so one bad beat is flagged once and framing recovers
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_pix   <= '0;
         exp_line  <= '0;
         seq_error <= 1'b0;
         s1        <= '0;
         s2        <= '0;
      end else begin
         s1.valid    <= bus.i_pix_valid;
         s1.line_end <= line_end;
         s1.pass_end <= pass_end;
         if (bus.i_pix_valid) begin
            s1.row_column_pointer <= MAX_PTR_W'(bus.i_row_column_pointer);
            s1.pixel_pointer      <= MAX_PTR_W'(bus.i_pixel_pointer);
            if (bus.i_row_column_pointer != exp_line || bus.i_pixel_pointer != exp_pix) begin
               seq_error <= 1'b1;
            end
            if (pass_end) begin
               exp_pix  <= '0;
               exp_line <= '0;
            end else if (line_end) begin
               exp_pix  <= '0;
               exp_line <= bus.i_row_column_pointer + PW'(1);
            end else begin
               exp_pix  <= bus.i_pixel_pointer + PW'(2);
               exp_line <= bus.i_row_column_pointer;
            end
         end
         s2.valid    <= s1.valid;
         s2.line_end <= s1.line_end;
         s2.pass_end <= s1.pass_end;
         if (s1.valid) begin
            s2.row_column_pointer <= s1.row_column_pointer;
            s2.pixel_pointer      <= s1.pixel_pointer;
         end
      end
   end

   haar_pair_kernel u_kernel (
      .clk        (clk),
      .rst        (rst),
      .pix        (bus.i_pix),
      .valid      (bus.i_pix_valid),
      .coef       (bus.o_coef),
      .coef_valid (kern_valid)
   );

   assign bus.o_coef_valid         = kern_valid;
   assign bus.o_row_column_pointer = PW'(s2.row_column_pointer);
   assign bus.o_pixel_pointer      = PW'(s2.pixel_pointer);
   assign bus.o_line_done          = s2.valid & s2.line_end;
   assign bus.o_pass_done          = s2.valid & s2.pass_end;
   assign bus.o_seq_error          = seq_error;

endmodule

// File: tb/tb_haar_lifting_mac.sv
// tb/tb_haar_lifting_mac.sv - randomized raster stimulus against a behavioural Haar/raster model
module tb_haar_lifting_mac;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int DL = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   haar_lifting_mac_if #(.WIDTH(W)) bus ();

   haar_lifting_mac #(.HEIGHT(H), .WIDTH(W), .DECOMPOSITION_LEVEL(DL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          v;
      logic [15:0] coef;
      int          rc;
      int          pp;
      bit          le;
      bit          pe;
   } beat_t;

   beat_t       m1;
   beat_t       m2;
   logic [15:0] hold_coef;
   int          hold_rc;
   int          hold_pp;
   int          em_pix;
   int          em_line;
   bit          m_seq;
   int          g_mode;
   int          g_level;
   int          checks;
   int          errors;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] haar(input int a, input int b);
      int d;
      int l;
      int h;
      d = a - b;
      l = (a + b) / 2;
      h = ((d >= 0) ? d / 2 : -((1 - d) / 2)) + 128;
      return {8'(l), 8'(h)};
   endfunction

   task automatic step(input bit v, input bit r, input int a, input int b, input int rc, input int pp);
      int    lvl;
      int    len;
      int    nl;
      beat_t nb;
      rst                      = r;
      bus.i_pix                = {8'(a), 8'(b)};
      bus.i_pix_valid          = v;
      bus.i_row_column_pointer = 3'(rc);
      bus.i_pixel_pointer      = 3'(pp);
      bus.i_mode               = 1'(g_mode);
      bus.i_level              = 3'(g_level);
      @(posedge clk);
      lvl = (g_level > DL) ? DL : g_level;
      len = (g_mode != 0 ? H : W) >> lvl;
      nl  = (g_mode != 0 ? W : H) >> lvl;
      if (r) begin
         m1.v = 0; m2.v = 0;
         hold_coef = '0; hold_rc = 0; hold_pp = 0;
         em_pix = 0; em_line = 0; m_seq = 0;
      end else begin
         m2 = m1;
         nb.v = v; nb.coef = haar(a, b); nb.rc = rc; nb.pp = pp;
         nb.le = (pp == len - 2);
         nb.pe = nb.le && (rc == nl - 1);
         m1 = nb;
         if (v) begin
            if (rc != em_line || pp != em_pix) m_seq = 1;
            if (nb.pe) begin
               em_pix = 0; em_line = 0;
            end else if (nb.le) begin
               em_pix = 0; em_line = rc + 1;
            end else begin
               em_pix = pp + 2; em_line = rc;
            end
         end
         if (m2.v) begin
            hold_coef = m2.coef; hold_rc = m2.rc; hold_pp = m2.pp;
         end
      end
      @(negedge clk);
      check("coef_valid", 32'(bus.o_coef_valid), 32'(m2.v));
      check("line_done", 32'(bus.o_line_done), 32'(m2.v && m2.le));
      check("pass_done", 32'(bus.o_pass_done), 32'(m2.v && m2.pe));
      check("coef", 32'(bus.o_coef), 32'(hold_coef));
      check("rc_ptr", 32'(bus.o_row_column_pointer), 32'(hold_rc));
      check("pix_ptr", 32'(bus.o_pixel_pointer), 32'(hold_pp));
      check("seq_error", 32'(bus.o_seq_error), 32'(m_seq));
   endtask

   task automatic idle();
      step(0, 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7));
   endtask

   task automatic raster(input int lines, input int len, input int skip_at);
      for (int rc = 0; rc < lines; rc++) begin
         for (int pp = 0; pp < len; pp += 2) begin
            if (!(rc == 0 && pp == skip_at)) begin
               repeat ($urandom_range(0, 2)) idle();
               step(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), rc, pp);
            end
         end
      end
      idle();
      idle();
   endtask

   initial begin
      checks = 0; errors = 0;
      g_mode = 0; g_level = 0;
      m1.v = 0; m2.v = 0;
      hold_coef = '0; hold_rc = 0; hold_pp = 0;
      em_pix = 0; em_line = 0; m_seq = 0;

      repeat (3) step(0, 1, 0, 0, 0, 0);
      idle();
      check("rst_coef", 32'(bus.o_coef), 32'h0);
      check("rst_valid", 32'(bus.o_coef_valid), 32'h0);
      check("rst_seq", 32'(bus.o_seq_error), 32'h0);

      step(1, 0, 200, 100, 0, 0);
      idle();
      check("first_coef", 32'(bus.o_coef), 32'h96B2);
      check("first_valid", 32'(bus.o_coef_valid), 32'h1);
      idle();
      check("first_single", 32'(bus.o_coef_valid), 32'h0);

      step(1, 0, 0, 255, 0, 2);
      step(1, 0, 255, 0, 0, 4);
      check("ext_0_255", 32'(bus.o_coef), 32'h7F00);
      step(1, 0, 0, 0, 0, 6);
      check("ext_255_0", 32'(bus.o_coef), 32'h7FFF);
      idle();
      check("ext_0_0", 32'(bus.o_coef), 32'h0080);
      check("ext_line_done", 32'(bus.o_line_done), 32'h1);
      idle();

      repeat (2) step(0, 1, 0, 0, 0, 0);
      raster(8, 8, -1);
      check("raster_seq", 32'(bus.o_seq_error), 32'h0);

      g_mode = 1; g_level = 1;
      raster(4, 4, -1);
      check("col_l1_seq", 32'(bus.o_seq_error), 32'h0);

      g_mode = 0; g_level = 0;
      raster(8, 8, 2);
      check("skip_sticky", 32'(bus.o_seq_error), 32'h1);

      step(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
      idle();
      step(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 2);
      step(1, 0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 4);
      step(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), 0, 6);
      check("inflight_drop", 32'(bus.o_coef_valid), 32'h0);
      idle();
      check("inflight_drop2", 32'(bus.o_coef_valid), 32'h0);
      check("post_rst_seq", 32'(bus.o_seq_error), 32'h0);
      step(1, 0, 77, 33, 0, 0);
      check("post_rst_lat1", 32'(bus.o_coef_valid), 32'h0);
      idle();
      check("post_rst_coef", 32'(bus.o_coef), 32'(haar(77, 33)));
      check("post_rst_valid", 32'(bus.o_coef_valid), 32'h1);
      idle();
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
